// File: rtl/idft_sched_pkg.sv
// Shared types and constants for the IDFT frame scheduler.
package idft_sched_pkg;

  localparam int BEAT_W = 64;

  typedef enum logic [1:0] {
    LOCKED,
    FILL,
    PRIME,
    FEED
  } idft_sched_state_t;

endpackage

// File: rtl/idft_frame_buf.sv
// Single-clock frame buffer: beats are written in arrival order at 'count'
// and read back by index.
module idft_frame_buf
  import idft_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [BEAT_W-1:0] rd_data,
  output logic [CW-1:0]     count
);

  logic [BEAT_W-1:0] mem [DEPTH];
  logic              do_wr;

  assign do_wr = wr_en && !clr && (count < CW'(DEPTH));

  // NOTE: the storage array has no reset; 'count' says which entries are
  // meaningful, and resetting a RAM would stop it mapping to memory cells.
  always_ff @(posedge clk) begin
    if (do_wr) mem[count[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (clr)   count <= '0;
    else if (do_wr) count <= count + CW'(1);
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/idft_frame_sched.sv
// Frame scheduler around an IDFT core: buffers a frame, primes and feeds the
// core, forwards results. Define IDFT_SCHED_STATS_EN for frames_in/frames_out.
module idft_frame_sched
  import idft_sched_pkg::*;
#(
  parameter int FRAME_BEATS  = 16,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  output logic              core_next,
  output logic [BEAT_W-1:0] core_x,
  input  logic              core_next_out,
  input  logic [BEAT_W-1:0] core_y,
  output logic              out_valid,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_last,
  output logic              err_drop
`ifdef IDFT_SCHED_STATS_EN
  ,
  output logic [31:0]       frames_in,
  output logic [31:0]       frames_out
`endif
);

  localparam int CW = $clog2(FRAME_BEATS + 1);
  localparam int AW = $clog2(FRAME_BEATS);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  idft_sched_state_t state;
  logic [CW-1:0]     buf_cnt;
  logic [CW-1:0]     feed_cnt;
  logic [BEAT_W-1:0] buf_rd_data;
  logic              buf_clr;
  logic              feed_done;
  logic [IW-1:0]     inflight;
  logic              ret_accept;
  logic              rx_act;
  logic              rx_drop;
  logic [CW-1:0]     rx_cnt;

  assign in_ready   = (state == FILL) && key_valid && (buf_cnt < CW'(FRAME_BEATS));
  assign feed_done  = (state == FEED) && (feed_cnt == CW'(FRAME_BEATS));
  assign buf_clr    = !key_valid || feed_done;
  assign ret_accept = core_next_out && (inflight != '0);

  idft_frame_buf #(.DEPTH(FRAME_BEATS)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (in_valid && in_ready),
    .wr_data (in_data),
    .rd_addr (feed_cnt[AW-1:0]),
    .rd_data (buf_rd_data),
    .count   (buf_cnt)
  );

  // NOTE: all state registers use non-blocking assignments so every block
  // sees pre-edge values, independent of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOCKED;
      core_next <= 1'b0;
      core_x    <= '0;
      feed_cnt  <= '0;
    end else if (!key_valid) begin
      state     <= LOCKED;
      core_next <= 1'b0;
      core_x    <= '0;
      feed_cnt  <= '0;
    end else begin
      case (state)
        LOCKED: state <= FILL;
        FILL: begin
          if (buf_cnt == CW'(FRAME_BEATS) && inflight < IW'(MAX_INFLIGHT)) begin
            state     <= PRIME;
            core_next <= 1'b1;
          end
        end
        PRIME: begin
          state     <= FEED;
          core_next <= 1'b0;
          core_x    <= buf_rd_data;
          feed_cnt  <= CW'(1);
        end
        FEED: begin
          if (feed_done) begin
            state    <= FILL;
            core_x   <= '0;
            feed_cnt <= '0;
          end else begin
            core_x   <= buf_rd_data;
            feed_cnt <= feed_cnt + CW'(1);
          end
        end
        default: state <= LOCKED;
      endcase
    end
  end

  // core_next marks the cycle a frame is committed to the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else if (core_next && !ret_accept) begin
      inflight <= inflight + IW'(1);
    end else if (ret_accept && !core_next) begin
      inflight <= inflight - IW'(1);
    end
  end

  // A frame whose key vanished is swallowed whole, with one err_drop pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_act    <= 1'b0;
      rx_drop   <= 1'b0;
      rx_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err_drop  <= 1'b0;
      if (rx_act) begin
        if (rx_drop || !key_valid) begin
          err_drop <= !rx_drop;
          rx_drop  <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_data  <= core_y;
          out_last  <= (rx_cnt == CW'(FRAME_BEATS - 1));
        end
        if (rx_cnt == CW'(FRAME_BEATS - 1)) rx_act <= 1'b0;
        else                                rx_cnt <= rx_cnt + CW'(1);
      end
      if (ret_accept) begin
        rx_act   <= 1'b1;
        rx_cnt   <= '0;
        rx_drop  <= !key_valid;
        err_drop <= !key_valid;
      end
    end
  end

`ifdef IDFT_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frames_in  <= '0;
      frames_out <= '0;
    end else begin
      if (core_next && frames_in != '1)  frames_in  <= frames_in + 32'd1;
      if (out_last && frames_out != '1)  frames_out <= frames_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idft_frame_sched.sv
// Directed testbench for idft_frame_sched with default parameters
// (16 beats per frame, 2 frames in flight).
module tb_idft_frame_sched;
  import idft_sched_pkg::*;

  localparam int FB = 16;

  logic              clk;
  logic              reset;
  logic              key_valid;
  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  logic              core_next;
  logic [BEAT_W-1:0] core_x;
  logic              core_next_out;
  logic [BEAT_W-1:0] core_y;
  logic              out_valid;
  logic [BEAT_W-1:0] out_data;
  logic              out_last;
  logic              err_drop;
`ifdef IDFT_SCHED_STATS_EN
  logic [31:0]       frames_in;
  logic [31:0]       frames_out;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cn_count = 0;
  int ov_count = 0;
  int ed_count = 0;

  idft_frame_sched dut (
    .clk           (clk),
    .reset         (reset),
    .key_valid     (key_valid),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .core_next     (core_next),
    .core_x        (core_x),
    .core_next_out (core_next_out),
    .core_y        (core_y),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .err_drop      (err_drop)
`ifdef IDFT_SCHED_STATS_EN
    ,
    .frames_in     (frames_in),
    .frames_out    (frames_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (core_next === 1'b1) cn_count <= cn_count + 1;
    if (out_valid === 1'b1) ov_count <= ov_count + 1;
    if (err_drop === 1'b1)  ed_count <= ed_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_valid = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    core_next_out = 1'b0;
    core_y = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] base, input int nbeats);
    int guard;
    for (int i = 0; i < nbeats; i++) begin
      guard = 0;
      in_valid = 1'b1;
      in_data = base + 64'(i);
      while (in_ready !== 1'b1 && guard < 300) begin
        tick();
        guard++;
      end
      if (guard >= 300) begin
        check("send_timeout", 64'(in_ready), 64'd1);
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_data = '0;
  endtask

  initial begin
    int base_cn, base_ov, base_ed, seen;

    // Reset values
    reset = 1'b1;
    key_valid = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    core_next_out = 1'b0;
    core_y = '0;
    #3;
    tick();
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_core_next", 64'(core_next), 64'd0);
    check("rst_core_x",    core_x,         64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data,       64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_err_drop",  64'(err_drop),  64'd0);
    check("rst_state",     64'(dut.state), 64'(LOCKED));

    // No key: upstream is held off and nothing is issued
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = 64'h1234;
    base_cn = cn_count;
    seen = 0;
    repeat (50) begin
      tick();
      if (in_ready === 1'b1) seen++;
    end
    check("locked_in_ready_seen", 64'(seen), 64'd0);
    check("locked_core_next", 64'(cn_count - base_cn), 64'd0);
    in_valid = 1'b0;

    // One frame 1..16 through to the core
    key_valid = 1'b1;
    tick();
    send_frame(64'd1, FB);
    check("next_not_early", 64'(core_next), 64'd0);
    tick();
    check("core_next_prime", 64'(core_next), 64'd1);
    check("core_x_prime", core_x, 64'd0);
    for (int i = 0; i < FB; i++) begin
      tick();
      check("feed_core_x", core_x, 64'(i + 1));
      if (i == 0) check("core_next_one_cycle", 64'(core_next), 64'd0);
    end
    tick();
    check("core_x_after_feed", core_x, 64'd0);

    // Result frame 0xA..0x19 forwarded with one cycle of latency
    core_next_out = 1'b1;
    tick();
    core_next_out = 1'b0;
    check("out_before_first", 64'(out_valid), 64'd0);
    for (int i = 0; i < FB; i++) begin
      core_y = 64'hA + 64'(i);
      tick();
      check("out_valid", 64'(out_valid), 64'd1);
      check("out_data", out_data, 64'hA + 64'(i));
      check("out_last", 64'(out_last), (i == FB - 1) ? 64'd1 : 64'd0);
    end
    core_y = '0;
    tick();
    check("out_valid_after", 64'(out_valid), 64'd0);

    // Stray core_next_out with nothing in flight is ignored
    base_ov = ov_count;
    base_ed = ed_count;
    core_next_out = 1'b1;
    tick();
    core_next_out = 1'b0;
    core_y = 64'h77;
    repeat (20) tick();
    core_y = '0;
    check("stray_out_valid", 64'(ov_count - base_ov), 64'd0);
    check("stray_err_drop", 64'(ed_count - base_ed), 64'd0);

    // Three frames queued: only two issue until one returns
    base_cn = cn_count;
    send_frame(64'd100, FB);
    send_frame(64'd200, FB);
    send_frame(64'd300, FB);
    repeat (30) tick();
    check("inflight_limit_pulses", 64'(cn_count - base_cn), 64'd2);
    core_next_out = 1'b1;
    tick();
    core_next_out = 1'b0;
    check("third_not_early", 64'(core_next), 64'd0);
    tick();
    check("third_after_return", 64'(core_next), 64'd1);
    tick();
    check("third_first_x", core_x, 64'd300);
    repeat (20) tick();
    check("third_total_pulses", 64'(cn_count - base_cn), 64'd3);

    // Key dropped at FEED beat 5, then the frame comes back while locked
    do_reset();
    key_valid = 1'b1;
    tick();
    send_frame(64'h50, FB);
    tick();
    check("drop_core_next", 64'(core_next), 64'd1);
    repeat (5) tick();
    check("drop_feed_beat5", core_x, 64'h54);
    key_valid = 1'b0;
    tick();
    check("drop_core_x", core_x, 64'd0);
    check("drop_state", 64'(dut.state), 64'(LOCKED));
    check("drop_in_ready", 64'(in_ready), 64'd0);
    repeat (3) tick();
    base_ov = ov_count;
    base_ed = ed_count;
    core_next_out = 1'b1;
    tick();
    core_next_out = 1'b0;
    check("drop_err_pulse", 64'(err_drop), 64'd1);
    check("drop_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < FB; i++) begin
      core_y = 64'h600 + 64'(i);
      tick();
    end
    core_y = '0;
    tick();
    check("drop_no_output", 64'(ov_count - base_ov), 64'd0);
    check("drop_single_err", 64'(ed_count - base_ed), 64'd1);

    // Reset at FILL beat 8: the partial frame is lost
    do_reset();
    key_valid = 1'b1;
    tick();
    send_frame(64'h900, 8);
    in_valid = 1'b1;
    in_data = 64'hDEAD;
    #1;
    check("fill_ready_before_reset", 64'(in_ready), 64'd1);
    reset = 1'b1;
    #1;
    check("ready_on_reset", 64'(in_ready), 64'd0);
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    base_cn = cn_count;
    tick();
    send_frame(64'hA00, FB - 1);
    repeat (10) tick();
    check("no_next_partial", 64'(cn_count - base_cn), 64'd0);
    check("ready_partial", 64'(in_ready), 64'd1);
    send_frame(64'hA0F, 1);
    check("refill_not_early", 64'(core_next), 64'd0);
    tick();
    check("refill_core_next", 64'(core_next), 64'd1);
    tick();
    check("refill_first_x", core_x, 64'hA00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
